// File: rtl/sata_phy_rx_monitor_pkg.sv
// Shared SATA PHY receive constants: ALIGN primitive, K mask, monitor state codes.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package sata_phy_rx_monitor_pkg;

    // ALIGN primitive as seen on the wire: K28.5 in byte 0, D10.2 D10.2 D27.3 above it
    localparam logic [31:0] PRIM_ALIGN   = 32'h7B4A4ABC;
    // Only byte 0 of an ALIGN carries a K character
    localparam logic [3:0]  ALIGN_K_MASK = 4'b0001;

    // Receive monitor state encodings; also exported on mon_state for debug
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_ACQUIRE = 2'd1;
    localparam logic [1:0]  ST_SYNCED  = 2'd2;
    localparam logic [1:0]  ST_LOST    = 2'd3;

    // Increment an 8-bit event counter, holding at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sata_prim_match.sv
// Compares a received dword/K pair against a primitive and flags unusable dwords.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle.
module sata_prim_match #(
    parameter logic [31:0] PRIM   = 32'h7B4A4ABC,
    parameter logic [3:0]  K_MASK = 4'b0001
) (
    input  logic [31:0] din,
    input  logic [3:0]  is_k,
    input  logic        byte_is_aligned,
    input  logic        elec_idle,
    input  logic        phy_error,
    output logic        match,
    output logic        bad
);

    // A dword with a decode error, lost comma alignment or idle line is unusable,
    // and an unusable dword is never accepted as a primitive even if the bits agree
    always_comb begin
        bad   = phy_error || !byte_is_aligned || elec_idle;
        match = (is_k == K_MASK) && (din == PRIM) && !bad;
    end

endmodule

// File: rtl/sata_phy_rx_monitor.sv
// Tracks receive sync from ALIGN spacing and dword errors, strips ALIGNs toward the link layer.
// Latency: datapath outputs are registered, one cycle after the input dword.
// Backpressure: none; the transceiver stream is consumed every cycle.
module sata_phy_rx_monitor
    import sata_phy_rx_monitor_pkg::*;
#(
    parameter int ALIGN_TIMEOUT = 1024,
    parameter int ERROR_LIMIT   = 4,
    parameter int SYNC_ALIGNS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        linkup,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_is_k,
    input  logic        rx_byte_is_aligned,
    input  logic        rx_elec_idle,
    input  logic        phy_error,
    output logic [31:0] rx_dout,
    output logic [3:0]  rx_is_k_out,
    output logic        rx_valid,
    output logic        align_detected,
    output logic        rx_ready,
    output logic        sync_lost,
    output logic [7:0]  sync_loss_count,
    output logic [1:0]  mon_state
);

    localparam int GAP_W = $clog2(ALIGN_TIMEOUT + 1);
    localparam int ERR_W = $clog2(ERROR_LIMIT + 1);
    localparam int ACQ_W = $clog2(SYNC_ALIGNS + 1);

    // Terminal values: a limit is reached when the counter already sits one below
    // it and the current dword is one more event of the same kind
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ALIGN_TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERROR_LIMIT - 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(SYNC_ALIGNS - 1);

    logic             align;
    logic             bad;

    logic [1:0]       state_q, state_d;
    logic [ACQ_W-1:0] acq_q, acq_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       loss_cnt_q;

    logic [31:0]      dout_q;
    logic [3:0]       is_k_q;
    logic             valid_q;
    logic             align_det_q;

    logic             gap_hit;
    logic             err_hit;

    sata_prim_match #(
        .PRIM   (PRIM_ALIGN),
        .K_MASK (ALIGN_K_MASK)
    ) u_align_match (
        .din             (rx_din),
        .is_k            (rx_is_k),
        .byte_is_aligned (rx_byte_is_aligned),
        .elec_idle       (rx_elec_idle),
        .phy_error       (phy_error),
        .match           (align),
        .bad             (bad)
    );

    // Limit detection for the current dword, shared by ACQUIRE and SYNCED
    always_comb begin
        gap_hit = !align && (gap_q == GAP_LAST);
        err_hit = bad && (err_q == ERR_LAST);
    end

    // Next-state and counter update; linkup low overrides everything and
    // every exit into IDLE or LOST leaves the counters clean for the next attempt
    always_comb begin
        state_d = state_q;
        acq_d   = acq_q;
        gap_d   = gap_q;
        err_d   = err_q;
        if (!linkup) begin
            state_d = ST_IDLE;
            acq_d   = '0;
            gap_d   = '0;
            err_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    acq_d   = '0;
                    gap_d   = '0;
                    err_d   = '0;
                end
                ST_ACQUIRE: begin
                    if (align) begin
                        gap_d = '0;
                        if (acq_q == ACQ_LAST) begin
                            state_d = ST_SYNCED;
                            acq_d   = '0;
                            err_d   = '0;
                        end else begin
                            acq_d = acq_q + ACQ_W'(1);
                        end
                    end else begin
                        acq_d = '0;
                        if (gap_hit) begin
                            state_d = ST_LOST;
                            gap_d   = '0;
                            err_d   = '0;
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                end
                ST_SYNCED: begin
                    gap_d = align ? '0 : gap_q + GAP_W'(1);
                    err_d = bad ? err_q + ERR_W'(1) : '0;
                    // Timeout and error limit together still mean one loss
                    if (gap_hit || err_hit) begin
                        state_d = ST_LOST;
                        acq_d   = '0;
                        gap_d   = '0;
                        err_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_ACQUIRE;
                    acq_d   = '0;
                    gap_d   = '0;
                    err_d   = '0;
                end
            endcase
        end
    end

    // State, sync counters and the sticky saturating loss count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acq_q      <= '0;
            gap_q      <= '0;
            err_q      <= '0;
            loss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            acq_q   <= acq_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            if (state_q == ST_LOST) begin
                loss_cnt_q <= sat_inc8(loss_cnt_q);
            end
        end
    end

    // One-cycle registered datapath; validity uses the state before this update,
    // so the acquiring ALIGN and anything before it never shows as valid
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q      <= '0;
            is_k_q      <= '0;
            valid_q     <= 1'b0;
            align_det_q <= 1'b0;
        end else begin
            dout_q      <= rx_din;
            is_k_q      <= rx_is_k;
            valid_q     <= (state_q == ST_SYNCED) && linkup && !align && !bad;
            align_det_q <= align && linkup;
        end
    end

    assign rx_dout         = dout_q;
    assign rx_is_k_out     = is_k_q;
    assign rx_valid        = valid_q;
    assign align_detected  = align_det_q;
    assign rx_ready        = (state_q == ST_SYNCED);
    assign sync_lost       = (state_q == ST_LOST);
    assign sync_loss_count = loss_cnt_q;
    assign mon_state       = state_q;

endmodule

// File: tb/tb_sata_phy_rx_monitor.sv
// Directed bench for the SATA RX sync monitor: vector table plus long-run sequences.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_sata_phy_rx_monitor;

    localparam logic [31:0] ALN = 32'h7B4A4ABC;

    logic        clk = 1'b0;
    logic        rst;
    logic        linkup;
    logic [31:0] rx_din;
    logic [3:0]  rx_is_k;
    logic        rx_byte_is_aligned;
    logic        rx_elec_idle;
    logic        phy_error;
    logic [31:0] rx_dout;
    logic [3:0]  rx_is_k_out;
    logic        rx_valid;
    logic        align_detected;
    logic        rx_ready;
    logic        sync_lost;
    logic [7:0]  sync_loss_count;
    logic [1:0]  mon_state;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    sata_phy_rx_monitor dut (
        .clk                (clk),
        .rst                (rst),
        .linkup             (linkup),
        .rx_din             (rx_din),
        .rx_is_k            (rx_is_k),
        .rx_byte_is_aligned (rx_byte_is_aligned),
        .rx_elec_idle       (rx_elec_idle),
        .phy_error          (phy_error),
        .rx_dout            (rx_dout),
        .rx_is_k_out        (rx_is_k_out),
        .rx_valid           (rx_valid),
        .align_detected     (align_detected),
        .rx_ready           (rx_ready),
        .sync_lost          (sync_lost),
        .sync_loss_count    (sync_loss_count),
        .mon_state          (mon_state)
    );

    typedef struct {
        logic        lk;
        logic [31:0] din;
        logic [3:0]  k;
        logic        ba;
        logic        ei;
        logic        pe;
        logic [1:0]  st;
        logic        rdy;
        logic        vld;
        logic        ad;
        logic        sl;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic lk, logic [31:0] din, logic [3:0] k, logic ba, logic ei,
                                logic pe, logic [1:0] st, logic rdy, logic vld, logic ad,
                                logic sl, logic [7:0] cnt);
        vec_t v;
        v.lk = lk; v.din = din; v.k = k; v.ba = ba; v.ei = ei; v.pe = pe;
        v.st = st; v.rdy = rdy; v.vld = vld; v.ad = ad; v.sl = sl; v.cnt = cnt;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Apply one dword, then sample just after the edge that consumes it
    task automatic drv(input logic lk, input logic [31:0] d, input logic [3:0] k,
                       input logic ba, input logic ei, input logic pe);
        linkup = lk; rx_din = d; rx_is_k = k;
        rx_byte_is_aligned = ba; rx_elec_idle = ei; phy_error = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic dat(input logic [31:0] d);
        drv(1'b1, d, 4'b0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic aln();
        drv(1'b1, ALN, 4'b0001, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic perr(input logic [31:0] d);
        drv(1'b1, d, 4'b0000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic chk_all(input string nm, input logic [1:0] st, input logic rdy,
                           input logic vld, input logic ad, input logic sl,
                           input logic [7:0] cnt, input logic [31:0] dout, input logic [3:0] k);
        cmp({nm, ".state"}, 32'(mon_state), 32'(st));
        cmp({nm, ".ready"}, 32'(rx_ready), 32'(rdy));
        cmp({nm, ".valid"}, 32'(rx_valid), 32'(vld));
        cmp({nm, ".align_det"}, 32'(align_detected), 32'(ad));
        cmp({nm, ".sync_lost"}, 32'(sync_lost), 32'(sl));
        cmp({nm, ".loss_cnt"}, 32'(sync_loss_count), 32'(cnt));
        cmp({nm, ".dout"}, rx_dout, dout);
        cmp({nm, ".k_out"}, 32'(rx_is_k_out), 32'(k));
    endtask

    initial begin
        //                lk din            k      ba  ei  pe  | st    rdy vld ad  sl  cnt
        tbl[0]  = mk(1, 32'h11111111, 4'h0, 1, 0, 0, 2'd1, 0, 0, 0, 0, 8'd0);
        tbl[1]  = mk(1, ALN,          4'h1, 1, 0, 0, 2'd1, 0, 0, 1, 0, 8'd0);
        tbl[2]  = mk(1, ALN,          4'h1, 1, 0, 0, 2'd2, 1, 0, 1, 0, 8'd0);
        tbl[3]  = mk(1, 32'h00000001, 4'h0, 1, 0, 0, 2'd2, 1, 1, 0, 0, 8'd0);
        tbl[4]  = mk(1, 32'h00000002, 4'h0, 1, 0, 1, 2'd2, 1, 0, 0, 0, 8'd0);
        tbl[5]  = mk(1, ALN,          4'h1, 1, 0, 1, 2'd2, 1, 0, 0, 0, 8'd0);
        tbl[6]  = mk(1, 32'h00000003, 4'h0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 8'd0);
        tbl[7]  = mk(1, 32'h00000004, 4'h0, 1, 0, 0, 2'd2, 1, 1, 0, 0, 8'd0);
        tbl[8]  = mk(1, 32'h00000005, 4'h0, 1, 1, 0, 2'd2, 1, 0, 0, 0, 8'd0);
        tbl[9]  = mk(1, 32'h00000006, 4'h0, 1, 0, 1, 2'd2, 1, 0, 0, 0, 8'd0);
        tbl[10] = mk(1, 32'h00000007, 4'h0, 1, 0, 1, 2'd2, 1, 0, 0, 0, 8'd0);
        tbl[11] = mk(1, 32'h00000008, 4'h0, 1, 0, 1, 2'd3, 0, 0, 0, 1, 8'd0);
        tbl[12] = mk(1, 32'h00000009, 4'h0, 1, 0, 0, 2'd1, 0, 0, 0, 0, 8'd1);
        tbl[13] = mk(1, ALN,          4'h3, 1, 0, 0, 2'd1, 0, 0, 0, 0, 8'd1);
        tbl[14] = mk(1, ALN,          4'h1, 1, 0, 0, 2'd1, 0, 0, 1, 0, 8'd1);
        tbl[15] = mk(1, ALN,          4'h1, 1, 0, 0, 2'd2, 1, 0, 1, 0, 8'd1);
        tbl[16] = mk(0, 32'h0000000A, 4'h0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'd1);
        tbl[17] = mk(0, ALN,          4'h1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'd1);
        tbl[18] = mk(1, 32'h0000000B, 4'h0, 1, 0, 0, 2'd1, 0, 0, 0, 0, 8'd1);
        tbl[19] = mk(1, ALN,          4'h1, 1, 0, 0, 2'd1, 0, 0, 1, 0, 8'd1);
        tbl[20] = mk(1, 32'h0000000C, 4'h0, 1, 0, 0, 2'd1, 0, 0, 0, 0, 8'd1);
        tbl[21] = mk(1, ALN,          4'h1, 1, 0, 0, 2'd1, 0, 0, 1, 0, 8'd1);
        tbl[22] = mk(1, ALN,          4'h1, 1, 0, 0, 2'd2, 1, 0, 1, 0, 8'd1);

        // Reset state
        rst = 1'b1;
        drv(1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0);
        chk_all("reset", 2'd0, 0, 0, 0, 0, 8'd0, 32'h0, 4'h0);
        rst = 1'b0;

        // Table: acquire, error handling, K mask, linkup drop, non-consecutive ALIGNs
        for (int i = 0; i < 23; i++) begin
            drv(tbl[i].lk, tbl[i].din, tbl[i].k, tbl[i].ba, tbl[i].ei, tbl[i].pe);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].rdy, tbl[i].vld, tbl[i].ad,
                    tbl[i].sl, tbl[i].cnt, tbl[i].din, tbl[i].k);
        end
        exp_cnt = 1;

        // Periodic ALIGN pairs with data 1..254 between them: stays synced
        for (int b = 0; b < 3; b++) begin
            for (int i = 1; i <= 254; i++) begin
                dat(32'(i));
                cmp("per.valid", 32'(rx_valid), 32'd1);
                cmp("per.dout", rx_dout, 32'(i));
                cmp("per.lost", 32'(sync_lost), 32'd0);
            end
            aln();
            cmp("per.aln_valid", 32'(rx_valid), 32'd0);
            cmp("per.aln_det", 32'(align_detected), 32'd1);
            aln();
            cmp("per.state", 32'(mon_state), 32'd2);
        end

        // 1024 data dwords with no ALIGN: loss on the 1024th, which is still valid
        for (int i = 1; i <= 1024; i++) begin
            dat(32'hA0000000 + 32'(i));
            if (i < 1024) begin
                if (mon_state !== 2'd2 || rx_valid !== 1'b1) begin
                    cmp("gap.early", {30'b0, mon_state}, 32'd2);
                    cmp("gap.early_valid", 32'(rx_valid), 32'd1);
                end
            end else begin
                chk_all("gap.lost", 2'd3, 0, 1, 0, 1, 8'(exp_cnt), 32'hA0000400, 4'h0);
            end
        end
        dat(32'h0);
        exp_cnt++;
        chk_all("gap.after", 2'd1, 0, 0, 0, 0, 8'(exp_cnt), 32'h0, 4'h0);

        // Three errors, a good dword, then four errors
        aln(); aln();
        cmp("err.sync", 32'(mon_state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            perr(32'h55);
            cmp("err.a_state", 32'(mon_state), 32'd2);
            cmp("err.a_valid", 32'(rx_valid), 32'd0);
        end
        dat(32'h66);
        cmp("err.good_valid", 32'(rx_valid), 32'd1);
        cmp("err.good_state", 32'(mon_state), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            perr(32'h77);
            cmp("err.b_valid", 32'(rx_valid), 32'd0);
            cmp("err.b_state", 32'(mon_state), (i == 4) ? 32'd3 : 32'd2);
        end
        cmp("err.lost", 32'(sync_lost), 32'd1);
        dat(32'h0);
        exp_cnt++;
        cmp("err.cnt", 32'(sync_loss_count), 32'(exp_cnt));
        cmp("err.after", 32'(mon_state), 32'd1);

        // Alternating ALIGN/data never acquires; then a full gap times out
        for (int i = 0; i < 20; i++) begin
            aln();
            cmp("alt.a_state", 32'(mon_state), 32'd1);
            dat(32'h88);
            cmp("alt.d_state", 32'(mon_state), 32'd1);
            cmp("alt.d_valid", 32'(rx_valid), 32'd0);
        end
        aln();
        for (int i = 1; i <= 1024; i++) begin
            dat(32'h99);
            if (i == 1024) cmp("acqto.lost", 32'(mon_state), 32'd3);
            else if (mon_state !== 2'd1) cmp("acqto.early", {30'b0, mon_state}, 32'd1);
        end
        dat(32'h0);
        exp_cnt++;
        cmp("acqto.cnt", 32'(sync_loss_count), 32'(exp_cnt));

        // Linkup drop while synced: IDLE, no loss pulse, count untouched
        aln(); aln();
        cmp("ldrop.sync", 32'(mon_state), 32'd2);
        drv(1'b0, 32'h1234, 4'h0, 1'b1, 1'b0, 1'b0);
        chk_all("ldrop.idle", 2'd0, 0, 0, 0, 0, 8'(exp_cnt), 32'h1234, 4'h0);
        drv(1'b0, 32'h1235, 4'h0, 1'b1, 1'b0, 1'b0);
        cmp("ldrop.nolost", 32'(sync_lost), 32'd0);
        cmp("ldrop.cnt", 32'(sync_loss_count), 32'(exp_cnt));

        // Drive losses up to 260 total; count holds at 255
        dat(32'h0);
        for (int n = exp_cnt + 1; n <= 260; n++) begin
            aln(); aln();
            perr(32'h1); perr(32'h2); perr(32'h3); perr(32'h4);
            cmp("sat.lost", 32'(sync_lost), 32'd1);
            dat(32'h0);
            exp_cnt = (n > 255) ? 255 : n;
            cmp("sat.cnt", 32'(sync_loss_count), 32'(exp_cnt));
        end

        // Reset mid-SYNCED clears everything including the loss count
        aln(); aln();
        dat(32'hCAFEF00D);
        cmp("rst.pre_valid", 32'(rx_valid), 32'd1);
        rst = 1'b1;
        dat(32'hCAFEF00E);
        chk_all("rst.mid", 2'd0, 0, 0, 0, 0, 8'd0, 32'h0, 4'h0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
